// File: rtl/reg_bank_sb.sv
// Parametrised register bank: two combinational read ports, one write port and a
// per-register pending-write scoreboard. Optional forwarding under REGBANK_BYPASS_EN.
module reg_bank_sb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 4,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] data,
  input  logic             write,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rs_busy,
  output logic             rt_busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic             w_wr_en;
  logic             w_rsv_en;
  logic [DEPTH-1:0] w_pend_nxt;

  // Register 0 swallows writes and reserves when hard-wired to zero
  assign w_wr_en  = write && !(ZERO_R0 && (rd == '0));
  assign w_rsv_en = rsv && !(ZERO_R0 && (rsv_addr == '0));

  // Reserve is applied after the write clear so a newer producer keeps the bit set
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en) begin
      w_pend_nxt[rd] = 1'b0;
    end
    if (w_rsv_en) begin
      w_pend_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[rd] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

`ifdef REGBANK_BYPASS_EN
  logic w_byp_rs;
  logic w_byp_rt;
  logic w_rsv_same;

  // Forwarding is suppressed while reset is held so the bank reads as cleared
  assign w_byp_rs   = rst_n && write && (rd == rs);
  assign w_byp_rt   = rst_n && write && (rd == rt);
  assign w_rsv_same = rsv && (rsv_addr == rd);
`endif

  always_comb begin
    rd1     = r_mem[rs];
    rs_busy = r_pend[rs];
`ifdef REGBANK_BYPASS_EN
    if (w_byp_rs) begin
      rd1     = data;
      rs_busy = w_rsv_same & r_pend[rs];
    end
`endif
    if (ZERO_R0 && (rs == '0)) begin
      rd1     = '0;
      rs_busy = 1'b0;
    end
  end

  always_comb begin
    rd2     = r_mem[rt];
    rt_busy = r_pend[rt];
`ifdef REGBANK_BYPASS_EN
    if (w_byp_rt) begin
      rd2     = data;
      rt_busy = w_rsv_same & r_pend[rt];
    end
`endif
    if (ZERO_R0 && (rt == '0)) begin
      rd2     = '0;
      rt_busy = 1'b0;
    end
  end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank for the processor datapath with two asynchronous read ports, one synchronous write port and a per-register scoreboard of pending-write bits. Decode reads operands through `rs`/`rt` and gets back data plus busy flags. Issue reserves a destination with `rsv`. Writeback commits with `write`, which clears the reservation. It is the successor of the fixed 16x32 two-read/one-write bank: width, depth and a hard-wired zero register are generalised, and hazard tracking is added.

## Interface
- `WIDTH`, 32, data width in bits
- `AW`, 4, address width; depth = 2^AW registers
- `ZERO_R0`, 0, when 1 register 0 reads as zero, ignores writes and never becomes pending
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rs`  in  AW  read address, port 1
- `rt`  in  AW  read address, port 2
- `rd`  in  AW  write address
- `data`  in  WIDTH  write data
- `write`  in  1  write enable
- `rsv`  in  1  reserve enable; marks `rsv_addr` pending
- `rsv_addr`  in  AW  register being reserved
- `rd1`  out  WIDTH  contents of `rs`
- `rd2`  out  WIDTH  contents of `rt`
- `rs_busy`  out  1  `rs` has a pending write
- `rt_busy`  out  1  `rt` has a pending write

## Operation
- Storage: 2^AW x WIDTH registers `mem[]` and a 2^AW-bit pending vector `pend[]`.
- Reset (`rst_n`=0, asynchronous): every `mem` entry = 0 and every `pend` bit = 0, so `rd1`=`rd2`=0 and `rs_busy`=`rt_busy`=0 while reset is held. Deassertion takes effect at the next rising edge.
- Read: `rd1`=`mem[rs]` and `rd2`=`mem[rt]`, both combinational. `rs`==`rt` is legal and gives identical outputs.
- Write: on a rising edge with `write`=1, `mem[rd]` <= `data` and `pend[rd]` <= 0.
- Reserve: on a rising edge with `rsv`=1, `pend[rsv_addr]` <= 1.
- Simultaneous `write` and `rsv` to the same address: the data is written and `pend` ends at 1, so the reserve wins because it belongs to a newer producer.
- Simultaneous `write` and `rsv` to different addresses: both take effect independently.
- Reserving an address that is already pending keeps it at 1. There is no count and no error flag.
- A write to a non-pending register is legal. It updates data and leaves `pend` at 0.
- With `ZERO_R0`=1:
  - `rd1`/`rd2` are 0 whenever the address is 0.
  - Writes to 0 are dropped.
  - Reserves of 0 are dropped, so busy for address 0 is always 0.
- Busy: `rs_busy`=`pend[rs]` and `rt_busy`=`pend[rt]`, modified by bypass when it is configured (see Configuration).
- No arithmetic is performed; all indices are AW bits wide, so there is no out-of-range address.

## Timing
- Read latency is 0 cycles, combinational from the address and current state.
- Write-to-read latency: the new value is visible on `rd1`/`rd2` in the cycle after the write edge. Within the write cycle the bypass configuration decides what is seen.
- Reserve-to-busy latency: busy rises in the cycle after the `rsv` edge. Reserve is never bypassed.
- Reset asserted in the middle of a write cycle: the asynchronous clear wins and the write is lost.
- Back-to-back writes to the same `rd`: the last one wins, one value per edge.

## Configuration
- `REGBANK_BYPASS_EN` defined: write-to-read forwarding is enabled. In any cycle with `write`=1 and `rd`==`rs`:
  - `rd1`=`data` and `rs_busy`=0, unless `rsv`=1 with `rsv_addr`==`rd` in the same cycle, in which case `rs_busy` = the current `pend[rs]`.
  - The same rule applies to `rt`/`rd2`/`rt_busy`.
  - The `ZERO_R0` masking still applies on top of forwarding.
- `REGBANK_BYPASS_EN` not defined: outputs reflect only registered state. During the write cycle a reader sees the old value and the old busy bit.

## Test plan
- Reset: set all registers non-zero, pulse `rst_n` low between edges → immediately `rd1`=`rd2`=0 and both busy flags 0 for every address.
- Write/read: write 234 to r0, then 340 to r3 (`ZERO_R0`=0) → next cycle `rs`=0,`rt`=3 gives `rd1`=234,`rd2`=340. With `ZERO_R0`=1 → `rd1`=0.
- Scoreboard: `rsv` r5 → `rs_busy`=1 from the next cycle. Write 0x55 to r5 → busy 0 and `rd1`=0x55 the cycle after.
- Same-cycle write and reserve of r7 with `data`=9 → afterwards `mem[7]`=9 and `rs_busy`=1.
- Bypass: `rs`=`rd`=2, `data`=0xABCD, `write`=1 → with the macro, `rd1`=0xABCD in the same cycle; without it, `rd1` holds the old value until the next cycle.
- Parametrisation: `WIDTH`=8,`AW`=3 → write 0xFF to r7 and 0x01 to r0, read both back. Depth-8 wrap: address 7 is accessible and no alias to r0 occurs.
